// File: rtl/morse_symbol_buffer_if.sv
// Word handoff bus between the Morse symbol buffer and the keyboard/decoder stage.
interface morse_symbol_buffer_if #(
    parameter int unsigned MAX_SYMBOLS = 16,
    parameter int unsigned LEN_W       = $clog2(MAX_SYMBOLS + 1)
);
    logic [2*MAX_SYMBOLS-1:0] word_data;
    logic [LEN_W-1:0]         word_len;
    logic                     word_valid;
    logic                     word_ready;

    modport master (
        output word_data,
        output word_len,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_data,
        input  word_len,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/morse_symbol_buffer.sv
// Morse entry front end: synchronise and debounce four switches, pack 2-bit symbol
// codes into a word buffer and hand completed words over a valid/ready bus.
module morse_symbol_buffer #(
    parameter int unsigned MAX_SYMBOLS     = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned LEN_W           = $clog2(MAX_SYMBOLS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sw_rectangle,
    input  logic                  sw_square,
    input  logic                  sw_space,
    input  logic                  sw_done,
    morse_symbol_buffer_if.master word,
    output logic                  overflow,
    output logic [1:0]            last_sym,
    output logic                  last_sym_valid,
    output logic                  busy
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_SYMBOLS);

    localparam logic [1:0] CODE_SPACE = 2'b10;
    localparam logic [1:0] CODE_DONE  = 2'b11;

    typedef enum logic [1:0] {StIdle, StCollect, StHold} state_e;

    // Bit index equals the symbol code: dot, dash, space, done.
    logic [3:0] sw_raw;
    assign sw_raw = {sw_done, sw_space, sw_rectangle, sw_square};

    logic [3:0]       sync1_q, sync2_q, deb_q, deb_prev_q, rise_q;
    logic [CNT_W-1:0] cnt_q [4];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            rise_q     <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q    <= sw_raw;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            rise_q     <= deb_q & ~deb_prev_q;
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    deb_q[i] <= ~deb_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    logic       ev_valid;
    logic [1:0] ev_code;

    always_comb begin
        ev_valid = |rise_q;
        ev_code  = 2'b00;
        if (rise_q[3])      ev_code = 2'b11;
        else if (rise_q[2]) ev_code = 2'b10;
        else if (rise_q[1]) ev_code = 2'b01;
    end

    state_e                   state_q, state_d;
    logic [2*MAX_SYMBOLS-1:0] data_q, data_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic                     valid_q, valid_d;
    logic                     overflow_q, overflow_d;
    logic [1:0]               last_sym_q, last_sym_d;
    logic                     lsv_q, lsv_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            data_q     <= '0;
            len_q      <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            last_sym_q <= 2'b00;
            lsv_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            len_q      <= len_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            last_sym_q <= last_sym_d;
            lsv_q      <= lsv_d;
        end
    end

    int unsigned prev_idx;
    int unsigned wr_idx;
    logic [1:0]  prev_code;

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        len_d      = len_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;
        last_sym_d = last_sym_q;
        lsv_d      = 1'b0;
        wr_idx     = (len_q < LEN_MAX) ? int'(len_q) : 0;
        prev_idx   = (len_q == '0) ? 0 : int'(len_q) - 1;
        prev_code  = data_q[2*prev_idx +: 2];

        case (state_q)
            StIdle: begin
                if (ev_valid && !ev_code[1]) begin
                    data_d[1:0] = ev_code;
                    len_d       = LEN_W'(1);
                    last_sym_d  = ev_code;
                    lsv_d       = 1'b1;
                    state_d     = StCollect;
                end
            end
            StCollect: begin
                if (ev_valid) begin
                    if (ev_code == CODE_DONE) begin
                        // A trailing letter separator is not part of the word.
                        if (prev_code == CODE_SPACE) begin
                            data_d[2*prev_idx +: 2] = 2'b00;
                            len_d                   = len_q - LEN_W'(1);
                        end
                        valid_d = 1'b1;
                        state_d = StHold;
                    end else if (len_q == LEN_MAX) begin
                        overflow_d = 1'b1;
                    end else if (!(ev_code == CODE_SPACE && prev_code == CODE_SPACE)) begin
                        data_d[2*wr_idx +: 2] = ev_code;
                        len_d                 = len_q + LEN_W'(1);
                        last_sym_d            = ev_code;
                        lsv_d                 = 1'b1;
                    end
                end
            end
            StHold: begin
                if (word.word_ready) begin
                    data_d     = '0;
                    len_d      = '0;
                    overflow_d = 1'b0;
                    valid_d    = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign word.word_data  = data_q;
    assign word.word_len   = len_q;
    assign word.word_valid = valid_q;
    assign overflow        = overflow_q;
    assign last_sym        = last_sym_q;
    assign last_sym_valid  = lsv_q;
    assign busy            = (state_q == StCollect);

endmodule

// File: tb/tb_morse_symbol_buffer.sv
// Directed bench for morse_symbol_buffer with a 4-symbol buffer and 4-cycle debounce.
module tb_morse_symbol_buffer;

    localparam int unsigned MAX_SYMBOLS = 4;
    localparam int unsigned DEB         = 4;
    localparam int unsigned LEN_W       = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;  // {done, space, rectangle, square}
    logic       overflow;
    logic [1:0] last_sym;
    logic       last_sym_valid;
    logic       busy;

    int tests = 0;
    int fails = 0;

    morse_symbol_buffer_if #(.MAX_SYMBOLS(MAX_SYMBOLS), .LEN_W(LEN_W)) word_if ();

    morse_symbol_buffer #(
        .MAX_SYMBOLS    (MAX_SYMBOLS),
        .DEBOUNCE_CYCLES(DEB),
        .LEN_W          (LEN_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sw_rectangle  (sw[1]),
        .sw_square     (sw[0]),
        .sw_space      (sw[2]),
        .sw_done       (sw[3]),
        .word          (word_if),
        .overflow      (overflow),
        .last_sym      (last_sym),
        .last_sym_valid(last_sym_valid),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Cumulative observation of the handshake and symbol strobe.
    int         valid_cnt = 0;
    int         lsv_cnt   = 0;
    logic [7:0] cap_data  = '0;
    logic [2:0] cap_len   = '0;
    logic       cap_ovf   = 1'b0;

    always @(negedge clk) begin
        if (word_if.word_valid) begin
            valid_cnt = valid_cnt + 1;
            cap_data  = word_if.word_data;
            cap_len   = word_if.word_len;
            cap_ovf   = overflow;
        end
        if (last_sym_valid) lsv_cnt = lsv_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int idx);
        @(negedge clk);
        sw[idx] = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        sw[idx] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic accept();
        @(negedge clk);
        word_if.word_ready = 1'b1;
        @(posedge clk);
        #1;
        check("accept_valid", word_if.word_valid, 0);
        check("accept_ovf", overflow, 0);
        check("accept_len", word_if.word_len, 0);
        @(negedge clk);
        word_if.word_ready = 1'b0;
    endtask

    int lat;
    int base_v;
    int base_l;

    initial begin
        rst_n              = 1'b0;
        sw                 = 4'b0000;
        word_if.word_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_len", word_if.word_len, 0);
        check("rst_data", word_if.word_data, 0);
        check("rst_valid", word_if.word_valid, 0);
        check("rst_ovf", overflow, 0);
        check("rst_last_sym", last_sym, 0);
        check("rst_lsv", last_sym_valid, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word rect, square, space, rect, done with the consumer always ready.
        word_if.word_ready = 1'b1;
        base_v             = valid_cnt;
        lat                = -1;
        @(negedge clk);
        sw[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (last_sym_valid && lat < 0) lat = k;
        end
        check("latency", lat, 7);
        check("first_last_sym", last_sym, 2'b01);
        @(negedge clk);
        sw[1] = 1'b0;
        repeat (10) @(posedge clk);
        pulse(0);
        pulse(2);
        pulse(1);
        check("w1_len_before_done", word_if.word_len, 4);
        check("w1_busy", busy, 1);
        pulse(3);
        check("w1_valid_cycles", valid_cnt - base_v, 1);
        check("w1_len", cap_len, 4);
        check("w1_data", cap_data, 8'b01_10_00_01);
        check("w1_ovf", cap_ovf, 0);
        check("w1_idle_busy", busy, 0);
        word_if.word_ready = 1'b0;

        // Three-cycle glitch is rejected.
        base_l = lsv_cnt;
        @(negedge clk);
        sw[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        sw[0] = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("glitch_lsv", lsv_cnt - base_l, 0);
        check("glitch_busy", busy, 0);

        // Overflow: five dots into a four-slot buffer, consumer stalled.
        for (int i = 0; i < 5; i++) pulse(0);
        check("ovf_lsv_count", lsv_cnt - base_l, 4);
        pulse(3);
        check("ovf_valid", word_if.word_valid, 1);
        check("ovf_len", word_if.word_len, 4);
        check("ovf_data", word_if.word_data, 8'h00);
        check("ovf_flag", overflow, 1);
        base_l = lsv_cnt;
        pulse(1);
        check("hold_dash_lsv", lsv_cnt - base_l, 0);
        check("hold_len", word_if.word_len, 4);
        check("hold_data", word_if.word_data, 8'h00);
        base_v = valid_cnt;
        repeat (20) @(posedge clk);
        #1;
        check("hold_20_cycles", valid_cnt - base_v, 20);
        accept();

        // Dash, space, space, done: duplicate space dropped, trailing space trimmed.
        pulse(1);
        pulse(2);
        pulse(2);
        check("sp_len_before_done", word_if.word_len, 2);
        pulse(3);
        check("sp_valid", word_if.word_valid, 1);
        check("sp_len", word_if.word_len, 1);
        check("sp_data", word_if.word_data, 8'b00_00_00_01);
        accept();

        // Dash and dot rising together: dash wins.
        @(negedge clk);
        sw[1] = 1'b1;
        sw[0] = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        sw[1] = 1'b0;
        sw[0] = 1'b0;
        repeat (10) @(posedge clk);
        pulse(3);
        check("pri_valid", word_if.word_valid, 1);
        check("pri_len", word_if.word_len, 1);
        check("pri_last_sym", last_sym, 2'b01);
        check("pri_data", word_if.word_data, 8'h01);
        accept();
        base_v = valid_cnt;
        pulse(3);
        check("idle_done_valid_cycles", valid_cnt - base_v, 0);
        check("idle_done_busy", busy, 0);

        // Reset in the middle of a word.
        pulse(0);
        pulse(1);
        pulse(0);
        check("mid_len", word_if.word_len, 3);
        check("mid_busy", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_len", word_if.word_len, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", word_if.word_valid, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_data", word_if.word_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        base_l = lsv_cnt;
        pulse(0);
        check("post_rst_lsv", lsv_cnt - base_l, 1);
        check("post_rst_len", word_if.word_len, 1);
        check("post_rst_last_sym", last_sym, 2'b00);
        check("post_rst_busy", busy, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/morse_symbol_buffer.md
Name: morse_symbol_buffer

Overview:
- Parametrised Morse entry front end. It replaces the ad-hoc combinational symbol append in the VGA/Morse top level.
- Synchronises and debounces the four Morse switches (dash, dot, space, done), then packs 2-bit symbol codes into a word buffer of configurable depth.
- Hands each completed word to the keyboard/decoder stage over a valid/ready handshake.
- Exports a last-symbol strobe and a busy flag that drive the VGA shape and yellow-screen logic.

Parameters:
- MAX_SYMBOLS, 16, word buffer depth in symbols (>=2).
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required before a switch level is accepted (>=1).
- LEN_W, $clog2(MAX_SYMBOLS+1), width of word_len.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous reset, active low
- sw_rectangle  input  1  raw dash switch, asynchronous
- sw_square  input  1  raw dot switch, asynchronous
- sw_space  input  1  raw letter-separator switch, asynchronous
- sw_done  input  1  raw end-of-word switch, asynchronous
- word_data  output  2*MAX_SYMBOLS  packed symbols; symbol k at bits [2k+1:2k]
- word_len  output  LEN_W  number of valid symbols in word_data
- word_valid  output  1  completed word available
- word_ready  input  1  consumer accepts the word
- overflow  output  1  sticky; at least one symbol was dropped because the buffer was full
- last_sym  output  2  code of the most recently stored symbol
- last_sym_valid  output  1  one-cycle pulse when a symbol is stored
- busy  output  1  high while in COLLECT

Behaviour:
- One clock domain. Reset applies on a clk edge with rst_n=0.
  - Reset values: word_data=0, word_len=0, word_valid=0, overflow=0, last_sym=0, last_sym_valid=0, busy=0, state=IDLE, debounced levels=0, debounce counters=0.
  - Reset mid-word or in HOLD discards all content.
- Symbol codes: dot=00, dash=01, space=10, done=11. The done code is never stored.
- Input conditioning, per switch:
  - 2-flop synchroniser, then a debounce counter.
  - The counter resets whenever the synchronised level equals the debounced level.
  - Otherwise it increments; on reaching DEBOUNCE_CYCLES the debounced level flips and the counter clears.
  - A rise pulse fires on a debounced 0->1 transition only. Falling edges produce no event.
- Latency: a clean raw rise first sampled at edge T produces last_sym_valid high in cycle T+DEBOUNCE_CYCLES+3, with the buffer updated the same cycle.
- Simultaneous rise pulses in one cycle: the highest priority is taken and the rest are discarded. Priority order is done > space > dash > dot.
- FSM:
  - IDLE
    - dot/dash: store at index 0, word_len=1, go to COLLECT.
    - space and done are ignored.
  - COLLECT (busy=1)
    - dot/dash: store at index word_len and increment.
    - space: stored only if the previous symbol is not a space; consecutive spaces are dropped silently.
    - Full: if word_len==MAX_SYMBOLS, dot/dash/space are dropped, overflow is set, and word_len and word_data are unchanged.
    - done: if the last stored symbol is a space, word_len decrements and that slot is zeroed in the same cycle. word_valid is then set and the FSM goes to HOLD.
  - HOLD (word_valid=1)
    - word_data and word_len are stable. All switch events are dropped and no last_sym_valid is issued.
    - On word_valid&&word_ready: clear word_data, word_len and overflow, deassert word_valid, return to IDLE. An event in the cycle after acceptance is processed normally.
- word_ready is ignored outside HOLD. word_valid never drops without acceptance.
- last_sym_valid is asserted only for stored symbols, never for dropped ones.
- Unused high slots of word_data always read 0.

Test Plan (DEBOUNCE_CYCLES=4, MAX_SYMBOLS=4):
- Reset, then pulse rectangle, square, space, rectangle, done, each held 10 cycles, with word_ready=1. Required: word_valid for 1 cycle with word_len=4, word_data=8'b01_10_00_01, overflow=0, and the first last_sym_valid at 7 cycles after the first sample.
- Square held high for only 3 cycles, then low. Required: no last_sym_valid, state stays IDLE, busy=0.
- Enter dot x5, then done, with word_ready=0 for 20 cycles. Required: word_len=4, word_data=8'h00, overflow=1, word_valid held for 20 cycles; dash events during HOLD are dropped. After word_ready=1: word_valid=0 and overflow=0 next cycle.
- Dash, space, space, done. Required: word_len=1, word_data=8'b00_00_00_01; the second space is dropped and the trailing space is trimmed.
- Dash and dot raised on the same cycle, then done. Required: word_len=1, last_sym=01. Done alone in IDLE produces no word_valid.
- rst_n low for 1 cycle while in COLLECT with 3 symbols stored. Required: next cycle word_len=0, busy=0, word_valid=0, overflow=0, and a following dot is stored at index 0.
